// File: rtl/cci_mpf_csrs_pkg.sv
// Shared CSR definitions for the MPF VTP statistics block.
// Event index enum doubles as the read-select encoding.
package cci_mpf_csrs_pkg;

  localparam int CCI_MPF_VTP_N_EVENTS = 6;

  typedef enum logic [2:0] {
    VTP_EV_4KB_HIT_C0 = 3'd0,
    VTP_EV_4KB_HIT_C1 = 3'd1,
    VTP_EV_4KB_MISS   = 3'd2,
    VTP_EV_2MB_HIT_C0 = 3'd3,
    VTP_EV_2MB_HIT_C1 = 3'd4,
    VTP_EV_2MB_MISS   = 3'd5,
    VTP_EV_OVF_FLAGS  = 3'd6
  } t_cci_mpf_vtp_event_idx;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } t_vtp_rd_state;

endpackage

// File: rtl/cci_mpf_event_counter.sv
// One registered-input event counter with sticky overflow flag.
// CCI_MPF_VTP_EVENT_SATURATE_EN selects saturate instead of wrap.
module cci_mpf_event_counter #(
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ev,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             ovf
);

  logic             r_ev;
  logic [WIDTH-1:0] r_value;
  logic             r_ovf;
  logic             w_full;

  assign w_full = &r_value;
  assign value  = r_value;
  assign ovf    = r_ovf;

  // Register the event, then accumulate it one edge later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ev    <= 1'b0;
      r_value <= '0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_ev    <= 1'b0;
      r_value <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ev <= ev;
      if (r_ev) begin
        if (w_full) begin
          r_ovf <= 1'b1;
`ifdef CCI_MPF_VTP_EVENT_SATURATE_EN
          r_value <= r_value;
`else
          r_value <= '0;
`endif
        end else begin
          r_value <= r_value + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cci_mpf_vtp_event_counters.sv
// VTP event counters with snapshot shadow bank and 1-cycle read port.
// Optional macro CCI_MPF_VTP_EVENT_SATURATE_EN makes counters saturate.
module cci_mpf_vtp_event_counters
  import cci_mpf_csrs_pkg::*;
#(
  parameter int CTR_WIDTH = 48,
  parameter int N_EVENTS  = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ev_4kb_hit_c0,
  input  logic        ev_4kb_hit_c1,
  input  logic        ev_4kb_miss,
  input  logic        ev_2mb_hit_c0,
  input  logic        ev_2mb_hit_c1,
  input  logic        ev_2mb_miss,
  input  logic        clr,
  input  logic        snap,
  input  logic        rd_req,
  input  logic [2:0]  rd_idx,
  output logic        rd_rsp_valid,
  output logic [63:0] rd_rsp_data
);

  localparam int N = CCI_MPF_VTP_N_EVENTS;

  if (N_EVENTS != CCI_MPF_VTP_N_EVENTS) begin : g_bad_n
    $error("N_EVENTS must equal CCI_MPF_VTP_N_EVENTS");
  end
  if (CTR_WIDTH < 8 || CTR_WIDTH > 64) begin : g_bad_w
    $error("CTR_WIDTH must be within 8..64");
  end

  logic [N-1:0]         w_ev;
  logic [CTR_WIDTH-1:0] w_value [N];
  logic [N-1:0]         w_ovf;
  logic [CTR_WIDTH-1:0] r_shadow [N];
  logic [N-1:0]         r_ovf_shadow;
  logic [63:0]          w_rd_data;
  t_vtp_rd_state        r_state;
  logic [63:0]          r_rd_data;

  assign w_ev = {ev_2mb_miss, ev_2mb_hit_c1,
                 ev_2mb_hit_c0, ev_4kb_miss,
                 ev_4kb_hit_c1, ev_4kb_hit_c0};

  for (genvar g = 0; g < N; g++) begin : g_ctr
    cci_mpf_event_counter #(
      .WIDTH (CTR_WIDTH)
    ) u_ctr (
      .clk     (clk),
      .reset_n (reset_n),
      .ev      (w_ev[g]),
      .clr     (clr),
      .value   (w_value[g]),
      .ovf     (w_ovf[g])
    );
  end

  // Shadow bank captures pre-edge live state, so clr+snap keeps old counts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) r_shadow[i] <= '0;
      r_ovf_shadow <= '0;
    end else if (snap) begin
      for (int i = 0; i < N; i++) r_shadow[i] <= w_value[i];
      r_ovf_shadow <= w_ovf;
    end
  end

  // Select a shadow word; index 7 reads as zero.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < N; i++) begin
      if (rd_idx == 3'(i)) w_rd_data = 64'(r_shadow[i]);
    end
    if (rd_idx == VTP_EV_OVF_FLAGS) w_rd_data = 64'(r_ovf_shadow);
  end

  // Read FSM: response one cycle after each request, data held otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= RD_IDLE;
      r_rd_data <= '0;
    end else begin
      unique case (r_state)
        RD_IDLE: if (rd_req) r_state <= RD_RESP;
        RD_RESP: if (!rd_req) r_state <= RD_IDLE;
        default: r_state <= RD_IDLE;
      endcase
      if (rd_req) r_rd_data <= w_rd_data;
    end
  end

  assign rd_rsp_valid = (r_state == RD_RESP);
  assign rd_rsp_data  = r_rd_data;

endmodule

// File: tb/tb_cci_mpf_vtp_event_counters.sv
// Directed bench for cci_mpf_vtp_event_counters (CTR_WIDTH=8).
// Wrap expectations follow CCI_MPF_VTP_EVENT_SATURATE_EN.
module tb_cci_mpf_vtp_event_counters;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ev_4kb_hit_c0 = 1'b0;
  logic        ev_4kb_hit_c1 = 1'b0;
  logic        ev_4kb_miss = 1'b0;
  logic        ev_2mb_hit_c0 = 1'b0;
  logic        ev_2mb_hit_c1 = 1'b0;
  logic        ev_2mb_miss = 1'b0;
  logic        clr = 1'b0;
  logic        snap = 1'b0;
  logic        rd_req = 1'b0;
  logic [2:0]  rd_idx = 3'd0;
  logic        rd_rsp_valid;
  logic [63:0] rd_rsp_data;

  int checks = 0;
  int errors = 0;

  cci_mpf_vtp_event_counters #(
    .CTR_WIDTH (8),
    .N_EVENTS  (6)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ev_4kb_hit_c0 (ev_4kb_hit_c0),
    .ev_4kb_hit_c1 (ev_4kb_hit_c1),
    .ev_4kb_miss   (ev_4kb_miss),
    .ev_2mb_hit_c0 (ev_2mb_hit_c0),
    .ev_2mb_hit_c1 (ev_2mb_hit_c1),
    .ev_2mb_miss   (ev_2mb_miss),
    .clr           (clr),
    .snap          (snap),
    .rd_req        (rd_req),
    .rd_idx        (rd_idx),
    .rd_rsp_valid  (rd_rsp_valid),
    .rd_rsp_data   (rd_rsp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ev(input logic [5:0] v);
    ev_4kb_hit_c0 = v[0];
    ev_4kb_hit_c1 = v[1];
    ev_4kb_miss   = v[2];
    ev_2mb_hit_c0 = v[3];
    ev_2mb_hit_c1 = v[4];
    ev_2mb_miss   = v[5];
  endtask

  task automatic hold_ev(input logic [5:0] v, input int n);
    set_ev(v);
    repeat (n) tick();
    set_ev(6'h0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic do_snap();
    snap = 1'b1;
    tick();
    snap = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] idx,
                         output logic v,
                         output logic [63:0] d);
    rd_req = 1'b1;
    rd_idx = idx;
    tick();
    v = rd_rsp_valid;
    d = rd_rsp_data;
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    logic v;
    logic [63:0] d;
    reset_n = 1'b0;
    repeat (2) tick();
    checks++;
    if (rd_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %0b expected 0", rd_rsp_valid);
    end
    checks++;
    if (rd_rsp_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_data: got %0h expected 0", rd_rsp_data);
    end
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      do_read(3'(i), v, d);
      checks++;
      if (v !== 1'b1 || d !== 64'd0) begin
        errors++;
        $display("FAIL reset_read idx%0d: got v=%0b d=%0h expected v=1 d=0",
                 i, v, d);
      end
    end
  endtask

  task automatic test_single_event();
    logic v;
    logic [63:0] d;
    hold_ev(6'b000100, 10);
    repeat (2) tick();
    do_snap();
    do_read(3'd2, v, d);
    checks++;
    if (v !== 1'b1 || d !== 64'd10) begin
      errors++;
      $display("FAIL miss_count: got v=%0b d=%0d expected v=1 d=10", v, d);
    end
    tick();
    checks++;
    if (rd_rsp_valid !== 1'b0 || rd_rsp_data !== 64'd10) begin
      errors++;
      $display("FAIL rsp_hold: got v=%0b d=%0d expected v=0 d=10",
               rd_rsp_valid, rd_rsp_data);
    end
    for (int i = 0; i < 8; i++) begin
      if (i != 2) begin
        do_read(3'(i), v, d);
        checks++;
        if (d !== 64'd0) begin
          errors++;
          $display("FAIL other_idx%0d: got %0d expected 0", i, d);
        end
      end
    end
  endtask

  task automatic test_all_events();
    do_clr();
    hold_ev(6'h3f, 3);
    repeat (2) tick();
    do_snap();
    rd_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rd_idx = 3'(i);
      tick();
      checks++;
      if (rd_rsp_valid !== 1'b1 ||
          rd_rsp_data !== ((i < 6) ? 64'd3 : 64'd0)) begin
        errors++;
        $display("FAIL b2b_idx%0d: got v=%0b d=%0d expected v=1 d=%0d",
                 i, rd_rsp_valid, rd_rsp_data, (i < 6) ? 3 : 0);
      end
    end
    rd_req = 1'b0;
    tick();
    checks++;
    if (rd_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got v=%0b expected 0", rd_rsp_valid);
    end
  endtask

  task automatic test_clear();
    logic v;
    logic [63:0] d;
    do_clr();
    for (int i = 0; i < 5; i++) begin
      hold_ev(6'b010000, 1);
      tick();
    end
    repeat (2) tick();
    do_snap();
    clr = 1'b1;
    set_ev(6'b010000);
    tick();
    clr = 1'b0;
    set_ev(6'h0);
    repeat (3) tick();
    do_read(3'd4, v, d);
    checks++;
    if (d !== 64'd5) begin
      errors++;
      $display("FAIL clr_old_shadow: got %0d expected 5", d);
    end
    do_snap();
    do_read(3'd4, v, d);
    checks++;
    if (d !== 64'd0) begin
      errors++;
      $display("FAIL clr_drop: got %0d expected 0", d);
    end
    clr = 1'b1;
    set_ev(6'b010000);
    tick();
    clr = 1'b0;
    tick();
    set_ev(6'h0);
    repeat (3) tick();
    snap = 1'b1;
    clr = 1'b1;
    tick();
    snap = 1'b0;
    clr = 1'b0;
    do_read(3'd4, v, d);
    checks++;
    if (d !== 64'd1) begin
      errors++;
      $display("FAIL clr_next_edge: got %0d expected 1", d);
    end
    do_snap();
    do_read(3'd4, v, d);
    checks++;
    if (d !== 64'd0) begin
      errors++;
      $display("FAIL clr_snap_same: got %0d expected 0", d);
    end
  endtask

  task automatic test_wrap();
    logic v;
    logic [63:0] d;
    logic [63:0] exp_val;
`ifdef CCI_MPF_VTP_EVENT_SATURATE_EN
    exp_val = 64'd255;
`else
    exp_val = 64'd1;
`endif
    do_clr();
    hold_ev(6'b000001, 257);
    repeat (2) tick();
    do_snap();
    do_read(3'd0, v, d);
    checks++;
    if (d !== exp_val) begin
      errors++;
      $display("FAIL wrap_value: got %0d expected %0d", d, exp_val);
    end
    do_read(3'd6, v, d);
    checks++;
    if (d !== 64'h1) begin
      errors++;
      $display("FAIL wrap_ovf: got %0h expected 1", d);
    end
  endtask

  task automatic test_snap_read_same();
    logic v;
    logic [63:0] d;
    do_clr();
    hold_ev(6'b001000, 7);
    repeat (2) tick();
    do_snap();
    hold_ev(6'b001000, 4);
    repeat (2) tick();
    snap = 1'b1;
    do_read(3'd3, v, d);
    snap = 1'b0;
    checks++;
    if (v !== 1'b1 || d !== 64'd7) begin
      errors++;
      $display("FAIL snap_read_old: got v=%0b d=%0d expected v=1 d=7", v, d);
    end
    do_read(3'd3, v, d);
    checks++;
    if (d !== 64'd11) begin
      errors++;
      $display("FAIL snap_read_new: got %0d expected 11", d);
    end
  endtask

  task automatic test_async_reset();
    logic v;
    logic [63:0] d;
    do_clr();
    hold_ev(6'h3f, 2);
    repeat (2) tick();
    do_snap();
    rd_req = 1'b1;
    rd_idx = 3'd1;
    tick();
    checks++;
    if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== 64'd2) begin
      errors++;
      $display("FAIL pre_reset: got v=%0b d=%0d expected v=1 d=2",
               rd_rsp_valid, rd_rsp_data);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (rd_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_drop: got v=%0b expected 0", rd_rsp_valid);
    end
    rd_req = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      do_read(3'(i), v, d);
      checks++;
      if (d !== 64'd0) begin
        errors++;
        $display("FAIL post_reset_shadow idx%0d: got %0d expected 0", i, d);
      end
    end
    do_snap();
    for (int i = 0; i < 7; i++) begin
      do_read(3'(i), v, d);
      checks++;
      if (d !== 64'd0) begin
        errors++;
        $display("FAIL post_reset_live idx%0d: got %0d expected 0", i, d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_all_events();
    test_clear();
    test_wrap();
    test_snap_read_same();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
